if_prefetch_unit: RTL and testbench

- Parametrised instruction-fetch stage and successor to the single-register PC generator.
- Owns the fetch PC and drives a variable-latency instruction-memory port with a req/ack request and rvalid response.
- Buffers fetched {pc, instr} pairs in a small prefetch FIFO and hands them to decode over a valid/ready handshake.
- Applies exception and jump redirects with flush, and discards stale in-flight responses.

---
 rtl/if_prefetch_unit.sv | 205 ++++++++++++++++++++
 tb/tb_if_prefetch_unit.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_unit.sv
// ============================================================================
// if_prefetch_unit
// ----------------------------------------------------------------------------
// Instruction-fetch stage. It owns the fetch PC and issues one request at a
// time to a variable-latency instruction memory using a req/ack request and an
// rvalid response. Fetched {pc, instr} pairs are buffered in a small prefetch
// FIFO and handed to decode over a valid/ready handshake. Exception and jump
// redirects reload the PC, flush the FIFO, and cause any response that is still
// in flight to be discarded.
//
// Ports
//   clk          clock; all state updates on the rising edge
//   rst          synchronous active-low reset
//   ce           fetch enable; 0 while in reset, 1 from the first edge after
//   excpt/ejpc   exception/interrupt redirect valid and target (has priority)
//   jCe/jAddr    jump/branch redirect valid and target
//   stall        blocks issuing new memory requests
//   imem_req     request valid
//   imem_addr    request address; stable while the request waits for ack
//   imem_ack     request accepted this cycle
//   imem_rvalid  response valid (one per accepted request)
//   imem_rdata   response data
//   out_valid    FIFO head valid
//   out_pc       head PC
//   out_instr    head instruction
//   out_ready    decode accepts the head
//   pc           current fetch PC (next address to request)
// ============================================================================
module if_prefetch_unit #(
    parameter int unsigned    AW       = 32,
    parameter int unsigned    DW       = 32,
    parameter logic [AW-1:0]  RESET_PC = '0,
    parameter int unsigned    PC_STEP  = 4,
    parameter int unsigned    DEPTH    = 4
) (
    input  logic          clk,
    input  logic          rst,
    output logic          ce,
    input  logic          excpt,
    input  logic [AW-1:0] ejpc,
    input  logic          jCe,
    input  logic [AW-1:0] jAddr,
    input  logic          stall,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic          imem_rvalid,
    input  logic [DW-1:0] imem_rdata,
    output logic          out_valid,
    output logic [AW-1:0] out_pc,
    output logic [DW-1:0] out_instr,
    input  logic          out_ready,
    output logic [AW-1:0] pc
);

    localparam int unsigned    PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned    CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
    localparam logic [AW-1:0]  STEP_C  = AW'(PC_STEP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t        state_q;
    state_t        state_d;

    logic          ce_q;
    logic [AW-1:0] pc_q;
    logic [AW-1:0] sent_addr_q;

    logic [AW-1:0] fifo_pc    [DEPTH];
    logic [DW-1:0] fifo_instr [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          accept;
    logic          push;
    logic          pop;

    assign redirect    = excpt | jCe;
    assign redirect_pc = excpt ? ejpc : jAddr;

    assign ce        = ce_q;
    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign out_valid = (count != '0);
    assign out_pc    = fifo_pc[rd_ptr];
    assign out_instr = fifo_instr[rd_ptr];
    assign pop       = out_valid & out_ready;

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        accept   = 1'b0;
        push     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // IDLE means nothing is outstanding, so the FIFO count alone
                // is the occupancy including the slot a new request reserves.
                if (ce_q && !stall && !redirect && (count < DEPTH_C)) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                imem_req = 1'b1;
                accept   = imem_ack;
                if (redirect) begin
                    // An accepted-but-stale request still owes a response.
                    state_d = imem_ack ? S_DRAIN : S_IDLE;
                end else if (imem_ack) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    push    = !redirect;
                    state_d = S_IDLE;
                end else if (redirect) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // PC, sent address, enable and FIFO bookkeeping
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            ce_q        <= 1'b0;
            pc_q        <= RESET_PC;
            sent_addr_q <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            ce_q <= 1'b1;

            if (redirect) begin
                pc_q <= redirect_pc;
            end else if (accept) begin
                pc_q <= pc_q + STEP_C;
            end

            // pc moves on at acceptance; remember the address the response
            // belongs to.
            if (accept) begin
                sent_addr_q <= pc_q;
            end

            if (redirect) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                unique case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= sent_addr_q;
            fifo_instr[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_if_prefetch_unit.sv
module tb_if_prefetch_unit;

    localparam logic [31:0] RPC  = 32'h0000_0100;
    localparam logic [31:0] RPC2 = 32'hFFFF_FFFC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ce, excpt, jCe, stall;
    logic [31:0] ejpc, jAddr;
    logic        imem_req, imem_ack, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_instr, pc;

    if_prefetch_unit #(
        .AW(32), .DW(32), .RESET_PC(RPC), .PC_STEP(4), .DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce),
        .excpt(excpt), .ejpc(ejpc), .jCe(jCe), .jAddr(jAddr), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
        .out_ready(out_ready), .pc(pc)
    );

    // Second instance: reset PC at the top of the address space.
    logic        ce2, req2, rvalid2, ov2;
    logic [31:0] addr2, rdata2, opc2, oin2, pc2;

    if_prefetch_unit #(
        .AW(32), .DW(32), .RESET_PC(RPC2), .PC_STEP(4), .DEPTH(4)
    ) dut_wrap (
        .clk(clk), .rst(rst), .ce(ce2),
        .excpt(1'b0), .ejpc(32'h0), .jCe(1'b0), .jAddr(32'h0), .stall(1'b0),
        .imem_req(req2), .imem_addr(addr2), .imem_ack(1'b1),
        .imem_rvalid(rvalid2), .imem_rdata(rdata2),
        .out_valid(ov2), .out_pc(opc2), .out_instr(oin2),
        .out_ready(1'b1), .pc(pc2)
    );

    int tests = 0;
    int fails = 0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'hC3A5};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ------------------------------------------------------------------------
    // Instruction memory model for the main instance
    // ------------------------------------------------------------------------
    int          ack_pct = 100;
    int          lat_min = 2;
    int          lat_max = 2;
    bit          mpend = 1'b0;
    int          mcnt = 0;
    logic [31:0] maddr = '0;
    bit          ev_acc, ev_rv;
    logic [31:0] ev_addr;

    initial begin
        imem_ack    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
    end

    always begin
        @(negedge clk);
        ev_acc  = imem_req && imem_ack;
        ev_addr = imem_addr;
        ev_rv   = imem_rvalid;
        @(posedge clk);
        #1;
        if (ev_rv) mpend = 1'b0;
        if (ev_acc) begin
            mpend = 1'b1;
            maddr = ev_addr;
            mcnt  = int'($urandom_range(lat_max, lat_min));
        end
        imem_rvalid = 1'b0;
        imem_ack    = 1'b0;
        if (mpend) begin
            if (mcnt <= 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_fn(maddr);
            end else begin
                mcnt--;
            end
        end else begin
            imem_ack = (int'($urandom_range(99, 0)) < ack_pct);
        end
    end

    // Memory for the wrap instance: always accepts, answers one cycle later.
    bit          a2;
    logic [31:0] ad2;
    initial begin
        rvalid2 = 1'b0;
        rdata2  = '0;
    end
    always begin
        @(negedge clk);
        a2  = req2;
        ad2 = addr2;
        @(posedge clk);
        #1;
        rvalid2 = a2;
        rdata2  = mem_fn(ad2);
    end

    // ------------------------------------------------------------------------
    // Reference model / scoreboard for the main instance.
    // Fetch stream after reset or redirect is base, base+4, ... ; any consumed
    // entry must be the next element of that stream.
    // ------------------------------------------------------------------------
    logic [31:0] exp_q[$];
    logic [31:0] exp_tail = '0;
    logic [31:0] exp_req = '0;
    logic [31:0] flush_target = '0;
    bit          chk_reset = 1'b0;
    bit          chk_ce = 1'b0;
    bit          chk_flush = 1'b0;
    bit          prev_rst_low = 1'b0;
    int          acc_cnt = 0;

    function automatic void restart(input logic [31:0] base);
        exp_q.delete();
        exp_tail = base;
        exp_req  = base;
    endfunction

    function automatic void refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back(exp_tail);
            exp_tail += 32'd4;
        end
    endfunction

    always @(negedge clk) begin
        logic [31:0] e;
        if (chk_reset) begin
            check("reset_ce", 32'(ce), 32'd0);
            check("reset_imem_req", 32'(imem_req), 32'd0);
            check("reset_out_valid", 32'(out_valid), 32'd0);
            check("reset_pc", pc, RPC);
        end
        if (chk_ce) check("ce_rise", 32'(ce), 32'd1);
        if (chk_flush) begin
            check("flush_out_valid", 32'(out_valid), 32'd0);
            check("redirect_pc", pc, flush_target);
        end
        chk_reset = 1'b0;
        chk_ce    = 1'b0;
        chk_flush = 1'b0;

        if (!rst) begin
            restart(RPC);
            chk_reset    = 1'b1;
            prev_rst_low = 1'b1;
        end else begin
            if (prev_rst_low) chk_ce = 1'b1;
            prev_rst_low = 1'b0;
            if (imem_req && imem_ack) begin
                acc_cnt++;
                check("req_addr", imem_addr, exp_req);
                exp_req += 32'd4;
            end
            if (out_valid && out_ready) begin
                refill();
                e = exp_q.pop_front();
                check("out_pc", out_pc, e);
                check("out_instr", out_instr, mem_fn(e));
            end
            if (excpt || jCe) begin
                flush_target = excpt ? ejpc : jAddr;
                restart(flush_target);
                chk_flush = 1'b1;
            end
        end
    end

    // Scoreboard for the wrap instance.
    logic [31:0] exp2_req = '0;
    logic [31:0] exp2_out = '0;
    always @(negedge clk) begin
        if (!rst) begin
            exp2_req = RPC2;
            exp2_out = RPC2;
        end else begin
            if (req2) begin
                check("wrap_req_addr", addr2, exp2_req);
                exp2_req += 32'd4;
            end
            if (ov2) begin
                check("wrap_out_pc", opc2, exp2_out);
                check("wrap_out_instr", oin2, mem_fn(exp2_out));
                exp2_out += 32'd4;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic wait_accept();
        int n0;
        bit got;
        n0  = acc_cnt;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (acc_cnt != n0) begin
                got = 1'b1;
                break;
            end
        end
        check("accept_wait", 32'(got), 32'd1);
    endtask

    initial begin
        int n0;
        int r;
        rst = 1'b0; excpt = 1'b0; jCe = 1'b0; stall = 1'b0;
        ejpc = '0; jAddr = '0; out_ready = 1'b1;

        // Reset then sequential fetch, 2-cycle memory.
        tick(3);
        rst = 1'b1;
        tick(30);

        // Backpressure: exactly DEPTH requests, then drain in order.
        rst = 1'b0;
        out_ready = 1'b0;
        tick(2);
        rst = 1'b1;
        n0 = acc_cnt;
        tick(40);
        check("bp_accepts", 32'(acc_cnt - n0), 32'd4);
        @(negedge clk);
        check("bp_req_idle", 32'(imem_req), 32'd0);
        tick(1);
        out_ready = 1'b1;
        tick(30);

        // Jump while waiting for a response.
        wait_accept();
        jCe = 1'b1; jAddr = 32'h200;
        tick(1);
        jCe = 1'b0;
        tick(30);

        // Simultaneous exception and jump.
        excpt = 1'b1; ejpc = 32'h80; jCe = 1'b1; jAddr = 32'h200;
        tick(1);
        excpt = 1'b0; jCe = 1'b0;
        tick(20);

        // Redirect under stall.
        stall = 1'b1;
        tick(8);
        excpt = 1'b1; ejpc = 32'h80;
        tick(1);
        excpt = 1'b0;
        n0 = acc_cnt;
        tick(10);
        check("stall_no_accept", 32'(acc_cnt - n0), 32'd0);
        @(negedge clk);
        check("stall_req_low", 32'(imem_req), 32'd0);
        check("stall_pc", pc, 32'h80);
        tick(1);
        stall = 1'b0;
        tick(20);

        // Reset while waiting; the late response must be ignored.
        lat_min = 3; lat_max = 3;
        wait_accept();
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(30);

        // Randomised traffic.
        ack_pct = 60; lat_min = 1; lat_max = 4;
        for (int c = 0; c < 2000; c++) begin
            out_ready = (int'($urandom_range(99, 0)) < 70);
            stall     = (int'($urandom_range(99, 0)) < 10);
            r         = int'($urandom_range(199, 0));
            excpt     = (r < 4) || (r == 10);
            jCe       = (r >= 4 && r < 10);
            case ($urandom_range(2, 0))
                0:       ejpc = 32'hFFFF_FFF8;
                1:       ejpc = $urandom & 32'hFFFF_FFFC;
                default: ejpc = $urandom;
            endcase
            jAddr = ($urandom_range(1, 0) == 0) ? 32'hFFFF_FFF4 : $urandom;
            rst   = (int'($urandom_range(999, 0)) >= 5);
            tick(1);
        end
        rst = 1'b1; excpt = 1'b0; jCe = 1'b0; stall = 1'b0; out_ready = 1'b1;
        tick(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
